vga_axil_regbank: RTL and testbench

Parametrised AXI4-Lite register bank that configures the VGA controller pipeline. It holds NUM_REGS writable 32-bit configuration registers and one read-only status register. Writes are double-buffered: they land in shadow registers and are committed to the active outputs only at a frame boundary, so the timing and pixel logic never sees a mid-frame change. It sits between the AXI interconnect and the VGA sync/pixel generator.

---
 rtl/vga_axil_regbank_if.sv | 37 +++
 rtl/vga_axil_regbank.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_vga_axil_regbank.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_axil_regbank_if.sv
// AXI4-Lite slave bus bundle for the VGA configuration register bank.
// Carries the five AXI4-Lite channels; clock and reset stay outside.
interface vga_axil_regbank_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/vga_axil_regbank.sv
// AXI4-Lite configuration register bank for the VGA pipeline.
// NUM_REGS writable 32-bit registers plus one read-only status register
// ({frame_cnt, 15'b0, pending}) at index NUM_REGS.
// Optional feature macro: VGA_REGBANK_SHADOW_EN. When defined, writes land
// in shadow registers and are committed to reg_out on a frame_start with
// pending set; when undefined, reg_out follows the shadow registers directly.
module vga_axil_regbank #(
  parameter int NUM_REGS           = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  vga_axil_regbank_if.slave       s_axi,
  input  logic                    frame_start,
  output logic [NUM_REGS*32-1:0]  reg_out,
  output logic                    commit_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // write channel state
  w_state_t          w_state_r, w_state_s;
  logic              awready_r, wready_r, bvalid_r;
  logic [1:0]        bresp_r;
  logic [IDX_W-1:0]  aw_idx_r;
  logic [31:0]       w_data_r;
  logic [3:0]        w_strb_r;
  logic              aw_hs_s, w_hs_s;
  logic              wr_en_s, wr_cfg_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [31:0]       wr_data_s;
  logic [3:0]        wr_strb_s;

  // read channel state
  r_state_t          r_state_r, r_state_s;
  logic              arready_r, rvalid_r;
  logic [31:0]       rdata_r;
  logic [1:0]        rresp_r;
  logic              ar_hs_s;
  logic [IDX_W-1:0]  ar_idx_s;
  logic [31:0]       rd_cfg_s, rd_data_s;
  logic [1:0]        rd_resp_s;

  // register storage
  logic [31:0]       shadow_r [NUM_REGS];
  logic [15:0]       frame_cnt_r;
  logic              pending_s;

  assign aw_hs_s  = s_axi.S_AXI_AWVALID & awready_r;
  assign w_hs_s   = s_axi.S_AXI_WVALID & wready_r;
  assign ar_hs_s  = s_axi.S_AXI_ARVALID & arready_r;
  assign ar_idx_s = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_cfg_s = wr_en_s & (wr_idx_s < STATUS_IDX);

  assign s_axi.S_AXI_AWREADY = awready_r;
  assign s_axi.S_AXI_WREADY  = wready_r;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = bresp_r;
  assign s_axi.S_AXI_ARREADY = arready_r;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;
  assign s_axi.S_AXI_RRESP   = rresp_r;

  // Write FSM next state; the register update fires when the second of AW/W is taken.
  always_comb begin
    w_state_s = w_state_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = aw_idx_r;
    wr_data_s = w_data_r;
    wr_strb_s = w_strb_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_state_s = W_RESP;
          wr_en_s   = 1'b1;
          wr_idx_s  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wr_data_s = s_axi.S_AXI_WDATA;
          wr_strb_s = s_axi.S_AXI_WSTRB;
        end else if (aw_hs_s) begin
          w_state_s = W_HAVE_ADDR;
        end else if (w_hs_s) begin
          w_state_s = W_HAVE_DATA;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) begin
          w_state_s = W_RESP;
          wr_en_s   = 1'b1;
          wr_data_s = s_axi.S_AXI_WDATA;
          wr_strb_s = s_axi.S_AXI_WSTRB;
        end else begin
          w_state_s = W_HAVE_ADDR;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) begin
          w_state_s = W_RESP;
          wr_en_s   = 1'b1;
          wr_idx_s  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
          w_state_s = W_HAVE_DATA;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_s = W_IDLE;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: w_state_s = W_IDLE;
    endcase
  end

  // Write FSM state register; readies/BVALID are registered copies of the next-state decode.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= (w_state_s == W_IDLE) || (w_state_s == W_HAVE_DATA);
      wready_r  <= (w_state_s == W_IDLE) || (w_state_s == W_HAVE_ADDR);
      bvalid_r  <= (w_state_s == W_RESP);
      if (wr_en_s) begin
        bresp_r <= wr_cfg_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Hold whichever half of the write arrived first until its partner shows up.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_r <= {IDX_W{1'b0}};
      w_data_r <= 32'd0;
      w_strb_r <= 4'd0;
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs_s) begin
        w_data_r <= s_axi.S_AXI_WDATA;
        w_strb_r <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  // Byte-lane update of the addressed shadow register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= 32'd0;
      end
    end else if (wr_cfg_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx_s == IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb_s[b]) begin
              shadow_r[i][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Frame counter, free-running modulo 2^16.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      frame_cnt_r <= 16'd0;
    end else if (frame_start) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  // Read data select: OR of masked shadows, then status / out-of-range decode.
  always_comb begin
    rd_cfg_s = 32'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_cfg_s = rd_cfg_s | (shadow_r[i] & {32{ar_idx_s == IDX_W'(i)}});
    end
    if (ar_idx_s < STATUS_IDX) begin
      rd_data_s = rd_cfg_s;
      rd_resp_s = RESP_OKAY;
    end else if (ar_idx_s == STATUS_IDX) begin
      rd_data_s = {frame_cnt_r, 15'd0, pending_s};
      rd_resp_s = RESP_OKAY;
    end else begin
      rd_data_s = 32'd0;
      rd_resp_s = RESP_SLVERR;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_s = R_DATA;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read FSM state register; RDATA/RRESP captured on the AR handshake (pre-write values).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= (r_state_s == R_IDLE);
      rvalid_r  <= (r_state_s == R_DATA);
      if (ar_hs_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_resp_s;
      end
    end
  end

`ifdef VGA_REGBANK_SHADOW_EN
  logic [31:0] active_r [NUM_REGS];
  logic        pending_r;
  logic        commit_pulse_r;

  assign pending_s    = pending_r;
  assign commit_pulse = commit_pulse_r;

  // Commit shadows to the active copy at a frame boundary when something changed.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_r[i] <= 32'd0;
      end
    end else if (frame_start && pending_r) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_r[i] <= shadow_r[i];
      end
    end
  end

  // Pending flag: a config write in the same cycle as a commit keeps it set.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pending_r <= 1'b0;
    end else if (wr_cfg_s) begin
      pending_r <= 1'b1;
    end else if (frame_start) begin
      pending_r <= 1'b0;
    end
  end

  // Commit strobe, high in the cycle following the commit edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      commit_pulse_r <= 1'b0;
    end else begin
      commit_pulse_r <= frame_start & pending_r;
    end
  end

  // Flatten the active registers onto reg_out.
  always_comb begin
    reg_out = {(NUM_REGS*32){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[32*i +: 32] = active_r[i];
    end
  end
`else
  assign pending_s    = 1'b0;
  assign commit_pulse = 1'b0;

  // Without double buffering the shadows drive reg_out directly.
  always_comb begin
    reg_out = {(NUM_REGS*32){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[32*i +: 32] = shadow_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_vga_axil_regbank.sv
// Directed self-checking bench for vga_axil_regbank (NUM_REGS=4, 8-bit address).
// Expectations adapt to whether VGA_REGBANK_SHADOW_EN is defined.
module tb_vga_axil_regbank;

`ifdef VGA_REGBANK_SHADOW_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         frame_start;
  logic [127:0] reg_out;
  logic         commit_pulse;
  int           total;
  int           bad;

  vga_axil_regbank_if #(.ADDR_WIDTH(8)) bus ();

  vga_axil_regbank #(.NUM_REGS(4), .C_S_AXI_ADDR_WIDTH(8)) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(bus),
    .frame_start(frame_start),
    .reg_out(reg_out),
    .commit_pulse(commit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_f, w_f;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 20) begin
      aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      if (aw_f) bus.S_AXI_AWVALID = 1'b0;
      if (w_f) bus.S_AXI_WVALID = 1'b0;
      n++;
    end
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_AXI_BVALID) begin
      total++; bad++;
      $display("FAIL write_timeout addr=%h: BVALID got %b required 1", addr, bus.S_AXI_BVALID);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      resp = 2'bxx;
    end else begin
      resp = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic drv_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic ar_f;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (bus.S_AXI_ARVALID && n < 20) begin
      ar_f = bus.S_AXI_ARREADY;
      @(negedge clk);
      if (ar_f) bus.S_AXI_ARVALID = 1'b0;
      n++;
    end
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_AXI_RVALID) begin
      total++; bad++;
      $display("FAIL read_timeout addr=%h: RVALID got %b required 1", addr, bus.S_AXI_RVALID);
      bus.S_AXI_ARVALID = 1'b0;
      data = 32'hxxxxxxxx; resp = 2'bxx;
    end else begin
      data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.S_AXI_AWREADY !== 1'b0) begin bad++; $display("FAIL rst_awready got %b required 0", bus.S_AXI_AWREADY); end
    total++; if (bus.S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL rst_wready got %b required 0", bus.S_AXI_WREADY); end
    total++; if (bus.S_AXI_ARREADY !== 1'b0) begin bad++; $display("FAIL rst_arready got %b required 0", bus.S_AXI_ARREADY); end
    total++; if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL rst_valids got %b%b required 00", bus.S_AXI_BVALID, bus.S_AXI_RVALID); end
    total++; if (bus.S_AXI_BRESP !== 2'b00 || bus.S_AXI_RRESP !== 2'b00 || bus.S_AXI_RDATA !== 32'd0) begin bad++; $display("FAIL rst_resp_data got %b %b %h required 00 00 0", bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA); end
    total++; if (reg_out !== 128'd0 || commit_pulse !== 1'b0) begin bad++; $display("FAIL rst_regout got %h/%b required 0/0", reg_out, commit_pulse); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin bad++; $display("FAIL rst_release_readies got %b required 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
  endtask

  task automatic test_basic();
    logic [1:0] resp;
    logic [31:0] data;
    logic [127:0] exp_out;
    for (int i = 0; i < 4; i++) begin
      drv_write(8'(4 * i), 32'(i + 1), 4'hF, resp);
      total++; if (resp !== 2'b00) begin bad++; $display("FAIL basic_bresp[%0d] got %b required 00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      drv_read(8'(4 * i), data, resp);
      total++; if (data !== 32'(i + 1) || resp !== 2'b00) begin bad++; $display("FAIL basic_read[%0d] got %h/%b required %h/00", i, data, resp, 32'(i + 1)); end
    end
    exp_out = SHADOW ? 128'd0 : {32'd4, 32'd3, 32'd2, 32'd1};
    total++; if (reg_out !== exp_out) begin bad++; $display("FAIL basic_regout got %h required %h", reg_out, exp_out); end
  endtask

  task automatic test_commit();
    logic [1:0] resp;
    logic [31:0] data;
    pulse_frame();
    total++; if (reg_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin bad++; $display("FAIL commit_regout got %h required 4/3/2/1", reg_out); end
    total++; if (commit_pulse !== SHADOW) begin bad++; $display("FAIL commit_pulse got %b required %b", commit_pulse, SHADOW); end
    @(negedge clk);
    total++; if (commit_pulse !== 1'b0) begin bad++; $display("FAIL commit_pulse_width got %b required 0", commit_pulse); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'h0001_0000 || resp !== 2'b00) begin bad++; $display("FAIL commit_status got %h/%b required 00010000/00", data, resp); end
    pulse_frame();
    total++; if (commit_pulse !== 1'b0 || reg_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin bad++; $display("FAIL idle_frame got %b/%h required 0/unchanged", commit_pulse, reg_out); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'h0002_0000) begin bad++; $display("FAIL idle_frame_status got %h required 00020000", data); end
  endtask

  task automatic test_out_of_order();
    logic [1:0] resp;
    logic [31:0] data;
    logic [63:0] exp_lo;
    // AW leads W by three cycles
    @(negedge clk);
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    total++; if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b1) begin bad++; $display("FAIL have_addr_readies got %b%b required 01", bus.S_AXI_AWREADY, bus.S_AXI_WREADY); end
    repeat (2) @(negedge clk);
    bus.S_AXI_WDATA = 32'hCAFE_0000; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin bad++; $display("FAIL bresp_hold[%0d] got %b/%b required 1/00", i, bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
      @(negedge clk);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    total++; if (bus.S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL bvalid_drop got %b required 0", bus.S_AXI_BVALID); end
    // W leads AW
    bus.S_AXI_WDATA = 32'h1122_3344; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    total++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL have_data_readies got %b%b required 10", bus.S_AXI_AWREADY, bus.S_AXI_WREADY); end
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    total++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin bad++; $display("FAIL w_first_bresp got %b/%b required 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
    repeat (4) @(negedge clk);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    drv_read(8'h00, data, resp);
    total++; if (data !== 32'hCAFE_0000) begin bad++; $display("FAIL aw_first_read got %h required cafe0000", data); end
    drv_read(8'h04, data, resp);
    total++; if (data !== 32'h1122_3344) begin bad++; $display("FAIL w_first_read got %h required 11223344", data); end
    exp_lo = SHADOW ? {32'd2, 32'd1} : {32'h1122_3344, 32'hCAFE_0000};
    total++; if (reg_out[63:0] !== exp_lo) begin bad++; $display("FAIL ooo_regout got %h required %h", reg_out[63:0], exp_lo); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [31:0] data;
    drv_write(8'h04, 32'hAABB_CCDD, 4'h5, resp);
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL strobe_bresp got %b required 00", resp); end
    drv_read(8'h04, data, resp);
    total++; if (data !== 32'h11BB_33DD) begin bad++; $display("FAIL strobe_read got %h required 11bb33dd", data); end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [31:0] data;
    pulse_frame();
    total++; if (commit_pulse !== SHADOW) begin bad++; $display("FAIL err_commit got %b required %b", commit_pulse, SHADOW); end
    total++; if (reg_out !== {32'd4, 32'd3, 32'h11BB_33DD, 32'hCAFE_0000}) begin bad++; $display("FAIL err_regout got %h required 4/3/11bb33dd/cafe0000", reg_out); end
    drv_write(8'h10, 32'hFFFF_FFFF, 4'hF, resp);
    total++; if (resp !== 2'b10) begin bad++; $display("FAIL status_write_bresp got %b required 10", resp); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'h0003_0000 || resp !== 2'b00) begin bad++; $display("FAIL status_after_write got %h/%b required 00030000/00", data, resp); end
    drv_read(8'h14, data, resp);
    total++; if (data !== 32'd0 || resp !== 2'b10) begin bad++; $display("FAIL oob_read got %h/%b required 0/10", data, resp); end
    drv_read(8'hFC, data, resp);
    total++; if (data !== 32'd0 || resp !== 2'b10) begin bad++; $display("FAIL oob_top_read got %h/%b required 0/10", data, resp); end
    drv_read(8'h0E, data, resp);
    total++; if (data !== 32'd4 || resp !== 2'b00) begin bad++; $display("FAIL low_bits_ignored got %h/%b required 4/00", data, resp); end
    drv_write(8'h14, 32'h1234_5678, 4'hF, resp);
    total++; if (resp !== 2'b10) begin bad++; $display("FAIL oob_write_bresp got %b required 10", resp); end
    drv_read(8'h10, data, resp);
    total++; if (data[0] !== 1'b0) begin bad++; $display("FAIL err_no_pending got %b required 0", data[0]); end
  endtask

  task automatic test_coincident();
    logic [1:0] resp;
    logic [31:0] data;
    logic [63:0] exp_hi;
    drv_write(8'h0C, 32'h0000_0044, 4'hF, resp);
    bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; frame_start = 1'b0;
    total++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin bad++; $display("FAIL coinc_bresp got %b/%b required 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
    total++; if (commit_pulse !== SHADOW) begin bad++; $display("FAIL coinc_commit got %b required %b", commit_pulse, SHADOW); end
    exp_hi = SHADOW ? {32'h0000_0044, 32'd3} : {32'h0000_0044, 32'h1234_5678};
    total++; if (reg_out[127:64] !== exp_hi) begin bad++; $display("FAIL coinc_regout got %h required %h", reg_out[127:64], exp_hi); end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    drv_read(8'h10, data, resp);
    total++; if (data !== {16'h0004, 15'd0, SHADOW}) begin bad++; $display("FAIL coinc_status got %h required %h", data, {16'h0004, 15'd0, SHADOW}); end
    pulse_frame();
    total++; if (commit_pulse !== SHADOW || reg_out[95:64] !== 32'h1234_5678) begin bad++; $display("FAIL coinc_next_commit got %b/%h required %b/12345678", commit_pulse, reg_out[95:64], SHADOW); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'h0005_0000) begin bad++; $display("FAIL coinc_status2 got %h required 00050000", data); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [31:0] data;
    @(negedge clk);
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h5555_AAAA; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 8'h00; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    total++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL b2b_latency got %b%b required 11", bus.S_AXI_BVALID, bus.S_AXI_RVALID); end
    total++; if (bus.S_AXI_RDATA !== 32'hCAFE_0000 || bus.S_AXI_RRESP !== 2'b00) begin bad++; $display("FAIL same_edge_read got %h/%b required cafe0000/00", bus.S_AXI_RDATA, bus.S_AXI_RRESP); end
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    total++; if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL b2b_release got %b%b required 00", bus.S_AXI_BVALID, bus.S_AXI_RVALID); end
    drv_write(8'h08, 32'h0000_0033, 4'h1, resp);
    drv_write(8'h08, 32'h0000_2200, 4'h2, resp);
    drv_read(8'h08, data, resp);
    total++; if (data !== 32'h1234_2233) begin bad++; $display("FAIL b2b_writes got %h required 12342233", data); end
    drv_read(8'h00, data, resp);
    total++; if (data !== 32'h5555_AAAA) begin bad++; $display("FAIL same_edge_after got %h required 5555aaaa", data); end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [31:0] data;
    @(negedge clk);
    frame_start = 1'b1;
    repeat (65530) @(negedge clk);
    frame_start = 1'b0;
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'hFFFF_0000) begin bad++; $display("FAIL wrap_max got %h required ffff0000", data); end
    total++; if (reg_out[95:0] !== {32'h1234_2233, 32'h11BB_33DD, 32'h5555_AAAA}) begin bad++; $display("FAIL wrap_regout got %h required 12342233/11bb33dd/5555aaaa", reg_out[95:0]); end
    pulse_frame();
    total++; if (commit_pulse !== 1'b0) begin bad++; $display("FAIL wrap_commit got %b required 0", commit_pulse); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'h0000_0000) begin bad++; $display("FAIL wrap_zero got %h required 00000000", data); end
  endtask

  task automatic test_reset_abort();
    logic [1:0] resp;
    logic [31:0] data;
    @(negedge clk);
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_ARADDR = 8'h04; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    total++; if (bus.S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL abort_pre_rvalid got %b required 1", bus.S_AXI_RVALID); end
    rst = 1'b1;
    #1;
    total++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_ARREADY !== 1'b0) begin bad++; $display("FAIL abort_async got rv=%b bv=%b awr=%b arr=%b required 0000", bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY); end
    total++; if (reg_out !== 128'd0) begin bad++; $display("FAIL abort_regout got %h required 0", reg_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL abort_no_resp got %b%b required 00", bus.S_AXI_BVALID, bus.S_AXI_RVALID); end
    drv_read(8'h00, data, resp);
    total++; if (data !== 32'd0) begin bad++; $display("FAIL abort_reg0 got %h required 0", data); end
    drv_read(8'h10, data, resp);
    total++; if (data !== 32'd0) begin bad++; $display("FAIL abort_status got %h required 0", data); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; frame_start = 1'b0;
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = 8'h00; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_basic();
    test_commit();
    test_out_of_order();
    test_strobe();
    test_errors();
    test_coincident();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
